mem_dp_arb: RTL and testbench
=============================

MEM_DP_ARB -- requirements
Module: mem_dp_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the memory port.
REQ-002 Parameter DWIDTH, default 16: data word width.
REQ-003 Parameter AWIDTH, default 10: memory address width.
REQ-004 Parameter LWIDTH, default 8: burst length field width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester burst request, level.
REQ-008 we  in  NREQ  per-requester direction: 1 write, 0 read.
REQ-009 base  in  NREQ*AWIDTH  per-requester burst start address, slice i = requester i.
REQ-010 len  in  NREQ*LWIDTH  per-requester burst length minus one (access count = len+1).
REQ-011 wdata  in  NREQ*DWIDTH  per-requester write data, consumed each granted write cycle.
REQ-012 mem_rdata  in  DWIDTH  read data from mem_dp port, valid one cycle after a read access.
REQ-013 gnt  out  NREQ  one-hot grant, held for the whole burst including DRAIN.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable, valid when mem_en=1.
REQ-016 mem_addr  out  AWIDTH  memory address.
REQ-017 mem_wdata  out  DWIDTH  memory write data, muxed from granted requester.
REQ-018 rvalid  out  1  rdata valid strobe.
REQ-019 rdata  out  DWIDTH  read data returned to granted requester.
REQ-020 done  out  NREQ  one-cycle one-hot completion pulse.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states IDLE, BURST, DRAIN.
REQ-023 IDLE: if any req bit set, select winner round-robin starting from index (last+1) mod NREQ; latch winner, we, base, len; assert gnt next cycle; go BURST. No req: stay IDLE, mem_en=0.
REQ-024 BURST: each cycle mem_en=1, mem_we=latched we, mem_addr=current address, mem_wdata=winner's wdata slice; address increments by 1, wraps modulo 2^AWIDTH; remaining count decrements.
REQ-025 BURST to DRAIN after the access with remaining count 0, i.e. exactly len+1 accesses.
REQ-026 DRAIN: mem_en=0, done[winner]=1 for one cycle, last rvalid of a read burst occurs here; next cycle IDLE, gnt cleared, last=winner.
REQ-027 rvalid=1 exactly one cycle after each read access (mem_en=1, mem_we=0); rdata=mem_rdata in that cycle; rvalid never asserts for writes.
REQ-028 Round-robin pointer advances only on burst completion; a requester holding req continuously cannot be granted twice while another request is pending.
REQ-029 req deassertion or change of base/len/we during BURST ignored; burst completes as latched.
REQ-030 Simultaneous requests: resolved only by round-robin order; minimum gap between bursts = 1 IDLE cycle.
REQ-031 len=2^LWIDTH-1: 2^LWIDTH accesses, counter must not overflow.

Reset
REQ-032 rst asserted (any time, including mid-burst): immediately state=IDLE, gnt=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, rdata=0, busy=0, last=NREQ-1 (so requester 0 wins first).
REQ-033 Aborted burst produces no done pulse; first arbitration after rst release occurs on the first rising edge with rst=0.

Verification
REQ-034 After reset, req=4'b0001, we=0, base0=10, len0=3 -> mem_addr 10,11,12,13 with mem_en=1 over 4 cycles, rvalid on 4 following cycles, done[0] pulse in DRAIN.
REQ-035 req=4'b1111 held, all len=0 -> grants in order 0,1,2,3,0; each burst 1 access + DRAIN + IDLE.
REQ-036 Write burst requester 2, base=1022, len=3, AWIDTH=10 -> addresses 1022,1023,0,1, mem_we=1, mem_wdata tracks wdata slice 2, no rvalid.
REQ-037 req1 dropped after first cycle of len=5 burst -> all 6 accesses still issued, done[1] pulses.
REQ-038 rst asserted during 3rd access of len=7 burst -> outputs zero immediately, no done; after release with req=4'b0100, requester 2 granted.
REQ-039 len=255 -> exactly 256 accesses, then DRAIN, count checked against scoreboard model.

Source files
------------

// File: rtl/mem_dp_arb.sv
// mem_dp_arb: round-robin arbiter that gives NREQ requesters burst access to one memory port.
module mem_dp_arb #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 10,
    parameter int LWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*AWIDTH-1:0]   base,
    input  logic [NREQ*LWIDTH-1:0]   len,
    input  logic [NREQ*DWIDTH-1:0]   wdata,
    input  logic [DWIDTH-1:0]        mem_rdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic [DWIDTH-1:0]        mem_wdata,
    output logic                     rvalid,
    output logic [DWIDTH-1:0]        rdata,
    output logic [NREQ-1:0]          done,
    output logic                     busy
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    state_t            state;
    logic [IW-1:0]     win, last, pick, idx;
    logic              any, we_l;
    logic [AWIDTH-1:0] addr;
    logic [LWIDTH-1:0] cnt;
    // Scan from farthest to nearest after last so the nearest requester is assigned last and wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            win    <= '0;
            last   <= IW'(NREQ - 1);
            we_l   <= 1'b0;
            addr   <= '0;
            cnt    <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= state == BURST && !we_l;
            case (state)
                IDLE: if (any) begin
                    win   <= pick;
                    we_l  <= we[pick];
                    addr  <= base[pick*AWIDTH +: AWIDTH];
                    cnt   <= len[pick*LWIDTH +: LWIDTH];
                    state <= BURST;
                end
                BURST: begin
                    addr  <= addr + 1'b1;
                    cnt   <= cnt - 1'b1;
                    state <= cnt == '0 ? DRAIN : BURST;
                end
                DRAIN: begin
                    last  <= win;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy      = state != IDLE;
    assign mem_en    = state == BURST;
    assign mem_we    = mem_en & we_l;
    assign mem_addr  = mem_en ? addr : '0;
    assign mem_wdata = mem_en ? wdata[win*DWIDTH +: DWIDTH] : '0;
    assign gnt       = busy ? NREQ'(1) << win : '0;
    assign done      = state == DRAIN ? NREQ'(1) << win : '0;
    assign rdata     = rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_dp_arb.sv
// tb_mem_dp_arb: randomized and directed bench for mem_dp_arb against a queue-based burst schedule model.
module tb_mem_dp_arb;
    localparam int NREQ = 4, DW = 16, AW = 10, LW = 8;
    logic                 clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]      req = '0, we = '0;
    logic [NREQ*AW-1:0]   base = '0;
    logic [NREQ*LW-1:0]   len = '0;
    logic [NREQ*DW-1:0]   wdata = '0;
    logic [DW-1:0]        mem_rdata = '0;
    logic [NREQ-1:0]      gnt, done;
    logic                 mem_en, mem_we, rvalid, busy;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata, rdata;
    int checks = 0, errors = 0, acc_cnt = 0;

    mem_dp_arb #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .base(base), .len(len), .wdata(wdata),
        .mem_rdata(mem_rdata), .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rvalid(rvalid), .rdata(rdata), .done(done), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Model: each granted burst becomes a list of per-cycle expectations (accesses then drain).
    typedef struct {int win; bit drain; bit we; int addr;} ent_t;
    ent_t q[$];
    int   last = NREQ - 1;
    bit   prev_rd = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            last = NREQ - 1;
            prev_rd = 0;
        end else if (q.size() == 0) begin
            prev_rd = 0;
            if (req != 0) begin
                int w;
                w = -1;
                for (int k = 1; k <= NREQ && w < 0; k++)
                    if (req[(last + k) % NREQ]) w = (last + k) % NREQ;
                for (int i = 0; i <= int'(len[w*LW +: LW]); i++)
                    q.push_back('{w, 1'b0, we[w], (int'(base[w*AW +: AW]) + i) % (1 << AW)});
                q.push_back('{w, 1'b1, 1'b0, 0});
            end
        end else begin
            ent_t e;
            e = q.pop_front();
            prev_rd = !e.drain && !e.we;
            if (e.drain) last = e.win;
        end
    end

    always @(negedge clk) begin
        int eg, ed, ea, ewd;
        bit ee, ewe;
        eg = 0; ed = 0; ea = 0; ewd = 0; ee = 0; ewe = 0;
        if (q.size() > 0) begin
            eg = 1 << q[0].win;
            ee = !q[0].drain;
            ewe = ee && q[0].we;
            ea = ee ? q[0].addr : 0;
            ewd = ee ? int'(wdata[q[0].win*DW +: DW]) : 0;
            ed = q[0].drain ? eg : 0;
        end
        chk("gnt", 32'(gnt), eg);
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("mem_en", 32'(mem_en), 32'(ee));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), ea);
        chk("mem_wdata", 32'(mem_wdata), ewd);
        chk("done", 32'(done), ed);
        chk("rvalid", 32'(rvalid), 32'(prev_rd));
        chk("rdata", 32'(rdata), prev_rd ? 32'(mem_rdata) : 0);
        if (mem_en) acc_cnt++;
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = DW'($urandom);
        for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
    end

    task automatic apply_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (busy && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic wait_done(input int r, input int bound, output bit seen);
        seen = 0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge clk);
            #1;
            if (done[r]) seen = 1;
        end
    endtask

    initial begin
        int order [5];
        int addrs [4];
        int n;
        bit seen;
        logic [NREQ-1:0] pg;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_mem_en", 32'(mem_en), 0);
        // Single read burst from requester 0 at address 10.
        req = 4'b0001; we = '0; base[0 +: AW] = 10; len[0 +: LW] = 3;
        apply_reset();
        @(posedge clk);
        #1 req = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_addr", 32'(mem_addr), 10 + i);
            chk("rd_en", 32'(mem_en), 1);
        end
        @(negedge clk);
        chk("rd_done", 32'(done), 1);
        chk("rd_last_rvalid", 32'(rvalid), 1);
        // All requesting with single-access bursts: strict rotation.
        req = 4'b1111; len = '0; we = '0;
        apply_reset();
        n = 0; pg = '0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (gnt != 0 && pg == 0) order[n++] = int'(gnt);
            pg = gnt;
        end
        chk("rr0", order[0], 1);
        chk("rr1", order[1], 2);
        chk("rr2", order[2], 4);
        chk("rr3", order[3], 8);
        chk("rr4", order[4], 1);
        req = '0;
        // Write burst wrapping the top of the address space.
        wait_idle();
        req = 4'b0100; we = 4'b0100; base[2*AW +: AW] = 1022; len[2*LW +: LW] = 3;
        addrs = '{1022, 1023, 0, 1};
        @(posedge clk);
        #1 req = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_addr", 32'(mem_addr), addrs[i]);
            chk("wr_we", 32'(mem_we), 1);
            chk("wr_rvalid", 32'(rvalid), 0);
        end
        // Request dropped after the first cycle still runs all six accesses.
        wait_idle();
        req = 4'b0010; we = '0; base[AW +: AW] = AW'($urandom); len[LW +: LW] = 5;
        @(posedge clk);
        #1 req = '0; acc_cnt = 0;
        wait_done(1, 20, seen);
        chk("drop_done", 32'(seen), 1);
        chk("drop_count", acc_cnt, 6);
        // Reset during the third access aborts the burst silently.
        wait_idle();
        req = 4'b0001; base[0 +: AW] = AW'($urandom); len[0 +: LW] = 7;
        @(posedge clk);
        #1 req = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_abort_en", 32'(mem_en), 1);
        rst = 1'b1;
        #1;
        chk("abort_en", 32'(mem_en), 0);
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        req = 4'b0100; we = '0; len[2*LW +: LW] = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("post_abort_gnt", 32'(gnt), 4);
        req = '0;
        // Maximum length burst.
        wait_idle();
        req = 4'b1000; we = '0; base[3*AW +: AW] = AW'($urandom); len[3*LW +: LW] = 8'hff;
        @(posedge clk);
        #1 req = '0; acc_cnt = 0;
        wait_done(3, 300, seen);
        chk("max_done", 32'(seen), 1);
        chk("max_count", acc_cnt, 256);
        // Random traffic.
        repeat (400) begin
            @(posedge clk);
            #1;
            req = NREQ'($urandom);
            we = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                base[i*AW +: AW] = AW'($urandom);
                len[i*LW +: LW] = LW'($urandom_range(0, 6));
            end
        end
        req = '0;
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
